// File: rtl/alu_pkg.sv
// alu_pkg: opcode constants and operand-inversion helper shared by the add/sub units
package alu_pkg;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;
  function automatic logic is_inv(input logic [2:0] op);
    return op == OP_SUB || op == OP_SLT;
  endfunction
endpackage

// File: rtl/addsub_seg.sv
// addsub_seg: combinational SEG_W-bit add/sub slice
//   a, b, b_invert, cin -> sum, cout (carry out of slice), c_msb_in (carry into slice MSB)
module addsub_seg #(
  parameter int SEG_W = 8
) (
  input  logic [SEG_W-1:0] a,
  input  logic [SEG_W-1:0] b,
  input  logic             b_invert,
  input  logic             cin,
  output logic [SEG_W-1:0] sum,
  output logic             cout,
  output logic             c_msb_in
);
  logic [SEG_W-1:0] be;
  assign be = b ^ {SEG_W{b_invert}};
  assign {cout, sum} = {1'b0, a} + {1'b0, be} + {{SEG_W{1'b0}}, cin};
  // sum bit = a ^ b ^ carry-in, so the carry into the MSB falls out of the sum bit
  assign c_msb_in = sum[SEG_W-1] ^ a[SEG_W-1] ^ be[SEG_W-1];
endmodule

// File: rtl/pipelined_addsub.sv
// pipelined_addsub: add/sub/slt resolving one SEG_W segment per stage, valid/ready on both sides
//   in_valid/in_ready/a_in/b_in/operation: operand beat
//   out_valid/out_ready/res/carry_out/overflow/zero: result beat, NSTAGE cycles later
module pipelined_addsub
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SEG_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic [2:0]       operation,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] res,
  output logic             carry_out,
  output logic             overflow,
  output logic             zero
);
  localparam int NSTAGE = WIDTH / SEG_W;
  logic adv;
  if (WIDTH % SEG_W != 0) begin : g_bad
    $error("pipelined_addsub: WIDTH must be a multiple of SEG_W");
  end
  assign adv = !out_valid || out_ready;
  assign in_ready = adv && !rst;
  // Stage word layout: low WIDTH bits hold result segments below k and operand-a segments
  // from k up; the bits above WIDTH hold the still-unconsumed operand-b segments k and up.
  for (genvar k = 0; k < NSTAGE; k++) begin : st
    localparam int IW = WIDTH + (NSTAGE - k) * SEG_W;
    logic [IW-1:0]    din;
    logic             vin, inv, slt, cin, cout, cmsb;
    logic [SEG_W-1:0] sum;
    logic [WIDTH-1:0] mix;
    if (k == 0) begin : src
      assign din = {b_in, a_in};
      assign vin = in_valid;
      assign inv = is_inv(operation);
      assign slt = operation == OP_SLT;
      assign cin = inv;
    end else begin : src
      assign din = st[k-1].mid.w_q;
      assign vin = st[k-1].mid.v_q;
      assign inv = st[k-1].mid.inv_q;
      assign slt = st[k-1].mid.slt_q;
      assign cin = st[k-1].mid.c_q;
    end
    addsub_seg #(.SEG_W(SEG_W)) u_seg (
      .a(din[k*SEG_W +: SEG_W]),
      .b(din[WIDTH +: SEG_W]),
      .b_invert(inv),
      .cin(cin),
      .sum(sum),
      .cout(cout),
      .c_msb_in(cmsb)
    );
    always_comb begin
      mix = din[WIDTH-1:0];
      mix[k*SEG_W +: SEG_W] = sum;
    end
    if (k < NSTAGE - 1) begin : mid
      logic [IW-SEG_W-1:0] w_q;
      logic                v_q, c_q, inv_q, slt_q;
      always_ff @(posedge clk) begin
        if (rst) v_q <= 1'b0;
        else if (adv) v_q <= vin;
        if (adv) begin
          w_q   <= {din[IW-1:WIDTH+SEG_W], mix};
          c_q   <= cout;
          inv_q <= inv;
          slt_q <= slt;
        end
      end
    end else begin : fin
      logic             ov;
      logic [WIDTH-1:0] r;
      logic [WIDTH-1:0] w_q;
      logic             v_q, c_q, ov_q, z_q;
      assign ov = cmsb ^ cout;
      assign r = slt ? {{(WIDTH-1){1'b0}}, mix[WIDTH-1] ^ ov} : mix;
      always_ff @(posedge clk)
        if (rst) begin
          v_q  <= 1'b0;
          w_q  <= '0;
          c_q  <= 1'b0;
          ov_q <= 1'b0;
          z_q  <= 1'b0;
        end else if (adv) begin
          v_q  <= vin;
          w_q  <= r;
          c_q  <= cout;
          ov_q <= ov;
          z_q  <= r == '0;
        end
    end
  end
  assign out_valid = st[NSTAGE-1].fin.v_q;
  assign res       = st[NSTAGE-1].fin.w_q;
  assign carry_out = st[NSTAGE-1].fin.c_q;
  assign overflow  = st[NSTAGE-1].fin.ov_q;
  assign zero      = st[NSTAGE-1].fin.z_q;
endmodule

// File: tb/tb_pipelined_addsub.sv
// tb_pipelined_addsub: random and directed checks of three pipelined_addsub configurations
module tb_pipelined_addsub;
  import alu_pkg::*;
  localparam int WD [3] = '{32, 16, 64};
  localparam int NS [3] = '{4, 1, 16};
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        iv [3], ir [3], ovl [3], ordy [3], co [3], of [3], zf [3];
  logic [63:0] a [3], b [3], r [3];
  logic [2:0]  op [3];
  logic [31:0] r0;
  logic [15:0] r1;
  logic [63:0] r2;
  int          checks = 0;
  int          errors = 0;
  always #5 clk = ~clk;
  assign r[0] = {32'd0, r0};
  assign r[1] = {48'd0, r1};
  assign r[2] = r2;
  pipelined_addsub #(.WIDTH(32), .SEG_W(8)) dut0 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .a_in(a[0][31:0]), .b_in(b[0][31:0]),
    .operation(op[0]), .out_valid(ovl[0]), .out_ready(ordy[0]), .res(r0), .carry_out(co[0]),
    .overflow(of[0]), .zero(zf[0]));
  pipelined_addsub #(.WIDTH(16), .SEG_W(16)) dut1 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .a_in(a[1][15:0]), .b_in(b[1][15:0]),
    .operation(op[1]), .out_valid(ovl[1]), .out_ready(ordy[1]), .res(r1), .carry_out(co[1]),
    .overflow(of[1]), .zero(zf[1]));
  pipelined_addsub #(.WIDTH(64), .SEG_W(4)) dut2 (
    .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]), .a_in(a[2]), .b_in(b[2]),
    .operation(op[2]), .out_valid(ovl[2]), .out_ready(ordy[2]), .res(r2), .carry_out(co[2]),
    .overflow(of[2]), .zero(zf[2]));
  task automatic check(input string tag, input logic [67:0] got, input logic [67:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  // Reference: plain integer arithmetic on w-bit values; returns {zero, overflow, carry, res}.
  function automatic logic [66:0] model(input int w, input logic [63:0] x_in, input logic [63:0] y_in,
                                        input logic [2:0] o);
    logic [63:0]        m, x, y, res;
    logic signed [65:0] sx, sy, st, lim;
    logic               sub, c, v;
    m   = (w == 64) ? '1 : (64'd1 << w) - 64'd1;
    x   = x_in & m;
    y   = y_in & m;
    sub = (o == OP_SUB) || (o == OP_SLT);
    sx  = x[w-1] ? $signed({2'b11, x | ~m}) : $signed({2'b00, x});
    sy  = y[w-1] ? $signed({2'b11, y | ~m}) : $signed({2'b00, y});
    st  = sub ? sx - sy : sx + sy;
    lim = 66'sd1 <<< (w - 1);
    v   = (st >= lim) || (st < -lim);
    c   = sub ? (x >= y) : (({1'b0, x} + {1'b0, y}) > {1'b0, m});
    res = (sub ? x - y : x + y) & m;
    if (o == OP_SLT) res = (sx < sy) ? 64'd1 : 64'd0;
    return {res == 64'd0, v, c, res};
  endfunction
  function automatic logic [63:0] operand(input int w);
    logic [63:0] m;
    m = (w == 64) ? '1 : (64'd1 << w) - 64'd1;
    case ($urandom_range(0, 4))
      0: return m;
      1: return 64'd1 << (w - 1);
      2: return (64'd1 << (w - 1)) - 64'd1;
      3: return 64'd0;
      default: return {$urandom, $urandom} & m;
    endcase
  endfunction
  function automatic logic [2:0] pick_op();
    case ($urandom_range(0, 3))
      0: return OP_ADD;
      1: return OP_SUB;
      2: return OP_SLT;
      default: return 3'($urandom);
    endcase
  endfunction
  task automatic rnd_beat(input int g);
    a[g]  = operand(WD[g]);
    b[g]  = operand(WD[g]);
    op[g] = pick_op();
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  // Scoreboard per DUT: expected results queued at input transfer, popped at output transfer.
  for (genvar g = 0; g < 3; g++) begin : mon
    logic [66:0] q [$];
    logic        hold = 1'b0;
    logic [66:0] held;
    always @(negedge clk) begin
      if (rst) begin
        q.delete();
        hold <= 1'b0;
      end else begin
        if (hold) check("hold", {ovl[g], zf[g], of[g], co[g], r[g]}, {1'b1, held});
        hold <= ovl[g] && !ordy[g];
        held <= {zf[g], of[g], co[g], r[g]};
        if (ovl[g] && ordy[g]) begin
          check("q_nonempty", 68'(q.size() != 0), 68'd1);
          if (q.size() != 0) check("result", {1'b0, zf[g], of[g], co[g], r[g]}, {1'b0, q.pop_front()});
        end
        if (iv[g] && ir[g]) q.push_back(model(WD[g], a[g], b[g], op[g]));
      end
    end
  end
  task automatic one(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                     input logic [34:0] e, input string tag);
    int n = 0;
    a[0] = {32'd0, x};
    b[0] = {32'd0, y};
    op[0] = o;
    iv[0] = 1'b1;
    check({tag, "_ready"}, 68'(ir[0]), 68'd1);
    tick();
    iv[0] = 1'b0;
    while (!ovl[0] && n < 40) begin
      tick();
      n++;
    end
    check({tag, "_lat"}, 68'(n), 68'(NS[0] - 1));
    check(tag, {33'd0, zf[0], of[0], co[0], r0}, {33'd0, e});
  endtask
  initial begin
    #300000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end
  initial begin
    int   sent, cyc;
    logic acc;
    logic acc3 [3];
    for (int g = 0; g < 3; g++) begin
      iv[g] = 1'b0;
      ordy[g] = 1'b1;
      a[g] = '0;
      b[g] = '0;
      op[g] = OP_ADD;
    end
    repeat (3) tick();
    for (int g = 0; g < 3; g++)
      check("reset", {ovl[g], ir[g], zf[g], of[g], co[g], r[g]}, 68'd0);
    rst = 1'b0;
    tick();
    one(OP_ADD, 32'hFFFF_FFFF, 32'h0000_0001, {1'b1, 1'b0, 1'b1, 32'h0000_0000}, "add_wrap");
    one(OP_SUB, 32'h8000_0000, 32'h0000_0001, {1'b0, 1'b1, 1'b1, 32'h7FFF_FFFF}, "sub_ovf");
    one(OP_SUB, 32'd5, 32'd7, {1'b0, 1'b0, 1'b0, 32'hFFFF_FFFE}, "sub_borrow");
    one(OP_SLT, 32'hFFFF_FFFF, 32'h0000_0001, {1'b0, 1'b0, 1'b1, 32'h0000_0001}, "slt_neg");
    one(OP_SLT, 32'h7FFF_FFFF, 32'h8000_0000, {1'b1, 1'b1, 1'b0, 32'h0000_0000}, "slt_ovf");
    one(3'b000, 32'd2, 32'd3, {1'b0, 1'b0, 1'b0, 32'h0000_0005}, "illegal_op");
    one(OP_SLT, 32'd5, 32'd5, {1'b1, 1'b0, 1'b1, 32'h0000_0000}, "slt_equal");
    sent = 0;
    cyc = 0;
    rnd_beat(0);
    iv[0] = 1'b1;
    while (sent < 8 && cyc < 60) begin
      ordy[0] = !(cyc >= 5 && cyc < 8);
      @(negedge clk);
      acc = ir[0];
      if (!ordy[0] && ovl[0]) check("stall_ready", 68'(ir[0]), 68'd0);
      tick();
      cyc++;
      if (acc) begin
        sent++;
        if (sent < 8) rnd_beat(0);
        else iv[0] = 1'b0;
      end
    end
    iv[0] = 1'b0;
    ordy[0] = 1'b1;
    check("stream_sent", 68'(sent), 68'd8);
    for (int i = 0; i < 40 && mon[0].q.size() != 0; i++) tick();
    check("stream_drain", 68'(mon[0].q.size()), 68'd0);
    repeat (2) tick();
    for (int i = 0; i < 3; i++) begin
      rnd_beat(0);
      iv[0] = 1'b1;
      tick();
    end
    iv[0] = 1'b0;
    rst = 1'b1;
    #1;
    check("rst_ready", 68'(ir[0]), 68'd0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      check("flush", 68'(ovl[0]), 68'd0);
      tick();
    end
    one(OP_ADD, 32'h1234_5678, 32'h1111_1111, {1'b0, 1'b0, 1'b0, 32'h2345_6789}, "after_rst");
    tick();
    for (int g = 1; g < 3; g++) begin
      rnd_beat(g);
      iv[g] = 1'b1;
    end
    for (int c = 0; c < 300; c++) begin
      for (int g = 1; g < 3; g++) ordy[g] = $urandom_range(0, 3) != 0;
      @(negedge clk);
      for (int g = 1; g < 3; g++) acc3[g] = iv[g] && ir[g];
      tick();
      for (int g = 1; g < 3; g++)
        if (acc3[g] || !iv[g]) begin
          rnd_beat(g);
          iv[g] = $urandom_range(0, 4) != 0;
        end
    end
    for (int g = 1; g < 3; g++) begin
      iv[g] = 1'b0;
      ordy[g] = 1'b1;
    end
    for (int i = 0; i < 60 && (mon[1].q.size() != 0 || mon[2].q.size() != 0); i++) tick();
    check("sweep16_drain", 68'(mon[1].q.size()), 68'd0);
    check("sweep64_drain", 68'(mon[2].q.size()), 68'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
